// File: rtl/iah_etc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iah_etc_pkg
// Description : Shared definitions for the IAH/ETC alert dispatch path:
//               dispatcher state encoding, alert level constants, outbound
//               payload field offsets and the payload packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package iah_etc_pkg;

  // Encoding is visible on state_out, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_BACKOFF  = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAIL     = 3'd6
  } state_e;

  localparam logic [1:0] LVL_MIN  = 2'd1;  // level 0 is promoted to this
  localparam logic [1:0] LVL_CRIT = 2'd3;  // skips the cancel window

  localparam int PAYLOAD_W  = 16;
  localparam int PL_SEQ_LSB = 8;   // seq[7:0]
  localparam int PL_LVL_LSB = 6;   // level[1:0]
  localparam int PL_ATT_LSB = 3;   // attempt[2:0]; bits [2:0] are zero

  function automatic logic [PAYLOAD_W-1:0] pack_payload(
    input logic [7:0] seq,
    input logic [1:0] lvl,
    input logic [2:0] att
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    p[PL_SEQ_LSB +: 8] = seq;
    p[PL_LVL_LSB +: 2] = lvl;
    p[PL_ATT_LSB +: 3] = att;
    return p;
  endfunction

endpackage : iah_etc_pkg
`default_nettype wire

// File: rtl/ms_timer.sv
`default_nettype none
// ============================================================================
// Module      : ms_timer
// Description : Loadable millisecond down-counter. Decrements on tick_1ms and
//               flags expiry when a tick arrives while the count is zero, so a
//               load of N expires on the (N+1)th tick (N to N+1 ms).
// Ports       : clk, rst      - clock, synchronous active-high reset
//               tick_1ms      - 1 ms strobe
//               load/load_val - reload the counter (wins over a tick)
//               expired       - combinational expiry strobe
// Revision    : 1.0 - initial release
// ============================================================================
module ms_timer #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1ms,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick_1ms && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = tick_1ms && (cnt_q == '0);

endmodule : ms_timer
`default_nettype wire

// File: rtl/alert_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alert_dispatch_ctrl
// Description : Turns the fused emergency alert into an outbound notification:
//               cancel window for levels 1-2, escalation on rising severity,
//               valid/ready transmit with ack/nack, timeout and bounded retry.
// Ports       : clk, rst, tick_1ms          - clock, sync reset, 1 ms strobe
//               alert_in, alert_level       - alert from the alert core
//               user_cancel                 - debounced cancel button
//               tx_ready, tx_ack, tx_nack   - transmitter handshake
//               tx_valid, tx_payload        - outbound payload
//               buzzer_out, fail_out        - local warning / failure flag
//               state_out                   - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module alert_dispatch_ctrl
  import iah_etc_pkg::*;
#(
  parameter int CANCEL_MS      = 3000,
  parameter int ACK_TIMEOUT_MS = 500,
  parameter int BACKOFF_MS     = 200,
  parameter int MAX_ATTEMPTS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1ms,
  input  logic        alert_in,
  input  logic [1:0]  alert_level,
  input  logic        user_cancel,
  input  logic        tx_ready,
  input  logic        tx_ack,
  input  logic        tx_nack,
  output logic        tx_valid,
  output logic [15:0] tx_payload,
  output logic        buzzer_out,
  output logic [2:0]  state_out,
  output logic        fail_out
);

  localparam int MAX_AB = (ACK_TIMEOUT_MS > BACKOFF_MS) ? ACK_TIMEOUT_MS : BACKOFF_MS;
  localparam int MAX_MS = (CANCEL_MS > MAX_AB) ? CANCEL_MS : MAX_AB;
  localparam int CNT_W  = $clog2(MAX_MS) + 1;
  localparam logic [2:0] MAX_ATT = 3'(MAX_ATTEMPTS);

  state_e      state_q, state_d;
  logic [7:0]  seq_q, seq_d;
  logic [1:0]  lvl_q, lvl_d;
  logic [2:0]  att_q, att_d;
  logic        tx_valid_q, tx_valid_d;
  logic [15:0] tx_payload_q, tx_payload_d;
  logic        buzzer_q, buzzer_d;
  logic        fail_q, fail_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_exp;

  // One timer, time-shared: only one of ARMED/WAIT_ACK/BACKOFF is active and
  // each reloads it on entry.
  ms_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .tick_1ms (tick_1ms),
    .load     (timer_load),
    .load_val (timer_val),
    .expired  (timer_exp)
  );

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    lvl_d      = lvl_q;
    att_d      = att_q;
    timer_load = 1'b0;
    timer_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (alert_in) begin
          lvl_d = (alert_level == 2'd0) ? LVL_MIN : alert_level;
          att_d = 3'd1;
          if (lvl_d == LVL_CRIT) begin
            state_d = ST_SEND;
          end else begin
            state_d    = ST_ARMED;
            timer_load = 1'b1;
            timer_val  = CNT_W'(CANCEL_MS);
          end
        end
      end
      ST_ARMED: begin
        // Cancel beats everything; alert_in dropping is deliberately ignored.
        if (user_cancel) begin
          state_d = ST_IDLE;
        end else begin
          if (alert_in && (alert_level > lvl_q)) begin
            lvl_d = alert_level;
          end
          if ((lvl_d == LVL_CRIT) || timer_exp) begin
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        if (tx_valid_q && tx_ready) begin
          state_d    = ST_WAIT_ACK;
          timer_load = 1'b1;
          timer_val  = CNT_W'(ACK_TIMEOUT_MS);
        end
      end
      ST_WAIT_ACK: begin
        if (tx_ack) begin
          state_d = ST_DONE;
          seq_d   = seq_q + 8'd1;
        end else if (tx_nack || timer_exp) begin
          if (att_q < MAX_ATT) begin
            state_d    = ST_BACKOFF;
            att_d      = att_q + 3'd1;
            timer_load = 1'b1;
            timer_val  = CNT_W'(BACKOFF_MS);
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_BACKOFF: begin
        if (timer_exp) begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        // Wait for the alert to go away so a held alert is not re-sent.
        if (!alert_in) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAIL: begin
        if (user_cancel || !alert_in) begin
          state_d = ST_IDLE;
          seq_d   = seq_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with
    // state_out. seq/level/attempt never change in SEND, which keeps the
    // payload frozen until the transfer.
    tx_valid_d   = (state_d == ST_SEND);
    tx_payload_d = (state_d == ST_SEND) ? pack_payload(seq_d, lvl_d, att_d) : tx_payload_q;
    fail_d       = (state_d == ST_FAIL);
    buzzer_d     = (state_d == ST_ARMED) || (state_d == ST_SEND) ||
                   (state_d == ST_WAIT_ACK) || (state_d == ST_BACKOFF) ||
                   (state_d == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      seq_q        <= '0;
      lvl_q        <= '0;
      att_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_payload_q <= '0;
      buzzer_q     <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      lvl_q        <= lvl_d;
      att_q        <= att_d;
      tx_valid_q   <= tx_valid_d;
      tx_payload_q <= tx_payload_d;
      buzzer_q     <= buzzer_d;
      fail_q       <= fail_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_payload = tx_payload_q;
  assign buzzer_out = buzzer_q;
  assign fail_out   = fail_q;
  assign state_out  = state_q;

endmodule : alert_dispatch_ctrl
`default_nettype wire

// File: tb/tb_alert_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alert_dispatch_ctrl
// Description : Self-checking bench for alert_dispatch_ctrl. A behavioural
//               model (deadline counting in ticks, plain integers) predicts
//               state and outputs each cycle; directed scenarios pin the
//               model with hand-computed values, then random traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alert_dispatch_ctrl;

  localparam int CANCEL_MS      = 3000;
  localparam int ACK_TIMEOUT_MS = 500;
  localparam int BACKOFF_MS     = 200;
  localparam int MAX_ATTEMPTS   = 4;

  localparam int M_IDLE = 0, M_ARMED = 1, M_SEND = 2, M_WAIT = 3,
                 M_BACKOFF = 4, M_DONE = 5, M_FAIL = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1ms = 1'b1;
  logic        alert_in = 1'b0;
  logic [1:0]  alert_level = 2'd0;
  logic        user_cancel = 1'b0;
  logic        tx_ready = 1'b0;
  logic        tx_ack = 1'b0;
  logic        tx_nack = 1'b0;
  logic        tx_valid;
  logic [15:0] tx_payload;
  logic        buzzer_out;
  logic [2:0]  state_out;
  logic        fail_out;

  always #5 clk = ~clk;

  alert_dispatch_ctrl #(
    .CANCEL_MS      (CANCEL_MS),
    .ACK_TIMEOUT_MS (ACK_TIMEOUT_MS),
    .BACKOFF_MS     (BACKOFF_MS),
    .MAX_ATTEMPTS   (MAX_ATTEMPTS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1ms    (tick_1ms),
    .alert_in    (alert_in),
    .alert_level (alert_level),
    .user_cancel (user_cancel),
    .tx_ready    (tx_ready),
    .tx_ack      (tx_ack),
    .tx_nack     (tx_nack),
    .tx_valid    (tx_valid),
    .tx_payload  (tx_payload),
    .buzzer_out  (buzzer_out),
    .state_out   (state_out),
    .fail_out    (fail_out)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each timed phase is a deadline: the phase ends on the (N+1)th tick seen.
  int m_mode = M_IDLE;
  int m_seq  = 0;
  int m_lvl  = 0;
  int m_att  = 0;
  int m_seen = 0;
  int m_need = 0;

  task automatic start_deadline(input int n);
    m_seen = 0;
    m_need = n + 1;
  endtask

  task automatic model_step();
    bit timed;
    if (rst) begin
      m_mode = M_IDLE; m_seq = 0; m_lvl = 0; m_att = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (alert_in) begin
        m_lvl = (alert_level == 0) ? 1 : int'(alert_level);
        m_att = 1;
        if (m_lvl == 3) m_mode = M_SEND;
        else begin m_mode = M_ARMED; start_deadline(CANCEL_MS); end
      end
      M_ARMED: begin
        if (user_cancel) m_mode = M_IDLE;
        else begin
          if (alert_in && int'(alert_level) > m_lvl) m_lvl = int'(alert_level);
          if (tick_1ms) m_seen++;
          if (m_lvl == 3 || (tick_1ms && m_seen == m_need)) m_mode = M_SEND;
        end
      end
      M_SEND: if (tx_ready) begin m_mode = M_WAIT; start_deadline(ACK_TIMEOUT_MS); end
      M_WAIT: begin
        timed = 1'b0;
        if (tick_1ms) begin m_seen++; timed = (m_seen == m_need); end
        if (tx_ack) begin
          m_mode = M_DONE; m_seq = (m_seq + 1) % 256;
        end else if (tx_nack || timed) begin
          if (m_att < MAX_ATTEMPTS) begin
            m_att++; m_mode = M_BACKOFF; start_deadline(BACKOFF_MS);
          end else m_mode = M_FAIL;
        end
      end
      M_BACKOFF: if (tick_1ms) begin
        m_seen++;
        if (m_seen == m_need) m_mode = M_SEND;
      end
      M_DONE: if (!alert_in) m_mode = M_IDLE;
      M_FAIL: if (user_cancel || !alert_in) begin
        m_mode = M_IDLE; m_seq = (m_seq + 1) % 256;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  always @(posedge clk) model_step();

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [15:0] e_pl;
    bit          e_buz;
    e_buz = (m_mode == M_ARMED) || (m_mode == M_SEND) || (m_mode == M_WAIT) ||
            (m_mode == M_BACKOFF) || (m_mode == M_FAIL);
    e_pl  = 16'((m_seq << 8) | (m_lvl << 6) | (m_att << 3));
    check("state", 32'(state_out), 32'(m_mode));
    check("tx_valid", 32'(tx_valid), 32'(m_mode == M_SEND));
    check("buzzer", 32'(buzzer_out), 32'(e_buz));
    check("fail_out", 32'(fail_out), 32'(m_mode == M_FAIL));
    if (m_mode == M_SEND) check("payload", 32'(tx_payload), 32'(e_pl));
  end

  // ---------------- stimulus ----------------
  task automatic wait_valid(output int n, input int limit);
    n = 0;
    do begin @(negedge clk); n++; end while (!tx_valid && n < limit);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},   32'(state_out),  32'd0);
    check({tag, "_valid"},   32'(tx_valid),   32'd0);
    check({tag, "_payload"}, 32'(tx_payload), 32'd0);
    check({tag, "_buzzer"},  32'(buzzer_out), 32'd0);
    check({tag, "_fail"},    32'(fail_out),   32'd0);
  endtask

  initial begin
    int  n;
    bit  saw;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Level 1, full cancel window, ack 10 cycles after transfer.
    alert_in = 1'b1; alert_level = 2'd1; tx_ready = 1'b1;
    wait_valid(n, 5000);
    check("arm_latency", 32'(n), 32'(CANCEL_MS + 2));
    check("pl_lvl1", 32'(tx_payload), 32'h0048);
    @(negedge clk);
    repeat (9) @(negedge clk);
    tx_ack = 1'b1; @(negedge clk); tx_ack = 1'b0;
    check("done_state", 32'(state_out), 32'd5);
    check("done_buzzer", 32'(buzzer_out), 32'd0);
    alert_in = 1'b0; @(negedge clk);

    // Level 3 goes straight to SEND, seq now 1.
    alert_in = 1'b1; alert_level = 2'd3;
    wait_valid(n, 10);
    check("crit_latency", 32'(n), 32'd1);
    check("pl_seq1", 32'(tx_payload), 32'h01C8);
    @(negedge clk);
    tx_ack = 1'b1; @(negedge clk); tx_ack = 1'b0;
    alert_in = 1'b0; @(negedge clk);

    // Level 2 cancelled at tick 1000: nothing sent.
    alert_in = 1'b1; alert_level = 2'd2; saw = 1'b0;
    repeat (1000) begin @(negedge clk); if (tx_valid) saw = 1'b1; end
    user_cancel = 1'b1; alert_in = 1'b0;
    @(negedge clk);
    user_cancel = 1'b0;
    check("cancel_state", 32'(state_out), 32'd0);
    check("cancel_no_tx", 32'(saw), 32'd0);

    // Level 1 escalated to 3 after 500 ticks, transmitter stalled.
    alert_in = 1'b1; alert_level = 2'd1; tx_ready = 1'b0;
    repeat (500) @(negedge clk);
    alert_level = 2'd3;
    wait_valid(n, 10);
    check("esc_latency", 32'(n), 32'd1);
    check("pl_esc", 32'(tx_payload), 32'h02C8);
    repeat (20) @(negedge clk);
    check("stall_valid", 32'(tx_valid), 32'd1);
    check("stall_payload", 32'(tx_payload), 32'h02C8);

    // Nack every attempt until FAIL.
    tx_ready = 1'b1;
    for (int i = 0; i < MAX_ATTEMPTS; i++) begin
      check("attempt_field", 32'(tx_payload[5:3]), 32'(i + 1));
      @(negedge clk);
      tx_nack = 1'b1; @(negedge clk); tx_nack = 1'b0;
      if (i < MAX_ATTEMPTS - 1) begin
        wait_valid(n, 400);
        check("backoff_gap", 32'(n), 32'(BACKOFF_MS + 1));
      end
    end
    check("fail_state", 32'(state_out), 32'd6);
    check("fail_flag", 32'(fail_out), 32'd1);
    user_cancel = 1'b1; @(negedge clk);
    check("fail_exit", 32'(state_out), 32'd0);
    user_cancel = 1'b0; alert_in = 1'b0; @(negedge clk);

    // No ack: timeout, retry, then reset while waiting.
    alert_in = 1'b1; alert_level = 2'd3;
    wait_valid(n, 10);
    check("pl_seq3", 32'(tx_payload), 32'h03C8);
    @(negedge clk);
    n = 0;
    do begin @(negedge clk); n++; end while (state_out != 3'd4 && n < 700);
    check("ack_timeout", 32'(n), 32'(ACK_TIMEOUT_MS + 1));
    wait_valid(n, 400);
    check("pl_retry", 32'(tx_payload), 32'h03D0);
    @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1'b1; @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0; alert_in = 1'b0; tx_ready = 1'b0;

    // Random traffic against the model.
    for (int c = 0; c < 30000; c++) begin
      @(negedge clk);
      tick_1ms    = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 399) == 0) alert_in = ~alert_in;
      if ($urandom_range(0, 49) == 0) alert_level = 2'($urandom_range(0, 3));
      user_cancel = ($urandom_range(0, 1999) == 0);
      tx_ready    = 1'($urandom_range(0, 1));
      tx_ack      = ($urandom_range(0, 99) < 3);
      tx_nack     = ($urandom_range(0, 99) < 3);
      rst         = ($urandom_range(0, 9999) == 0);
    end
    @(negedge clk);
    rst = 1'b0; tx_ack = 1'b0; tx_nack = 1'b0; user_cancel = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_alert_dispatch_ctrl
`default_nettype wire
